rom_fetch_unit: RTL
===================

Name: rom_fetch_unit

Overview:
Instruction fetch front-end that drives the address of the synchronous single-port instruction ROM (1-cycle registered read latency) and consumes its data. Returns each fetched word with its word address to decode over a valid/ready handshake. Sustains one instruction per cycle, absorbs back-pressure without losing reads, and supports a redirect for branches, jumps and traps.

Parameters:
memSize_p, 8, ROM word-address width; depth is 2**memSize_p words
dataWidth_p, 32, instruction word width
resetPc_p, 0, word address fetched first after reset

Ports:
clk_i  input  1  clock; all state updates on rising edge
reset_i  input  1  synchronous, active-high reset
rom_addr_o  output  memSize_p  ROM read address; equals internal pc_q
rom_data_i  input  dataWidth_p  ROM read data for the address presented on the previous edge
redirect_i  input  1  flush and restart fetch at redirect_addr_i
redirect_addr_i  input  memSize_p  redirect target word address
instr_o  output  dataWidth_p  head-entry instruction word
instr_addr_o  output  memSize_p  head-entry word address
valid_o  output  1  head entry valid
ready_i  input  1  consumer accepts the head entry when valid_o & ready_i

Behaviour:
- State: pc_q (next address to issue), inflight_q plus tag_q (one outstanding read and its address), and a 2-entry FIFO of {instr, addr} with count_q of 0..2.
- Reset values: pc_q=resetPc_p, inflight_q=0, tag_q=0, count_q=0, FIFO storage=0. So valid_o=0, instr_o=0, instr_addr_o=0, rom_addr_o=resetPc_p.
- pop = valid_o & ready_i.
- issue = ~reset_i & ~redirect_i & ((count_q + inflight_q - pop) < 2).
- On issue: tag_q<=pc_q, inflight_q<=1, pc_q<=pc_q+1. Otherwise inflight_q<=0 and pc_q holds.
- pc_q arithmetic is modulo 2**memSize_p; the address after all-ones wraps to 0.
- Push: when inflight_q=1, {rom_data_i, tag_q} enters the FIFO at that edge. Push and pop in the same edge leave count_q unchanged. Push order equals issue order.
- Overflow is impossible by construction (credit check). An assertion fires if a push occurs with count_q=2 and no pop.
- ROM data returned for cycles with no issue is ignored.
- Latency: the first edge with reset_i low issues resetPc_p. valid_o rises after the second edge.
- Throughput: with ready_i held 1, one instruction per cycle at consecutive addresses, no bubbles.
- Stall: with ready_i=0 at most 2 entries are held. Issue stops once count_q+inflight_q=2. The head stays stable (instr_o, instr_addr_o and valid_o unchanged) until accepted.
- Redirect (redirect_i=1 at an edge):
  - pc_q<=redirect_addr_i; FIFO cleared (count_q<=0); inflight_q<=0; no issue that edge.
  - An in-flight read is discarded.
  - A pop coinciding with redirect is treated as accepted by the consumer; its entry is discarded either way.
  - valid_o is 0 for the next 2 cycles. First valid entry, at redirect_addr_i, appears after the 3rd edge counting the redirect edge.
- Back-to-back redirects: the last one wins, and each restarts the latency.
- reset_i has priority over redirect_i. Reset mid-operation behaves like a redirect to resetPc_p, with FIFO storage zeroed.

Decomposition:
- Shared package corisc_fetch_pkg:
  - FETCH_ROM_LATENCY=1
  - FETCH_BUF_DEPTH=2
  - fetch entry record {instr, addr}, widths derived from module parameters
- One natural sub-module: fetch_skid_fifo, a 2-entry synchronous FIFO with push, pop, flush, count, head outputs and synchronous active-high reset.
- Top level holds pc_q, the inflight/tag tracking and the issue logic.

Test Plan:
ROM image: word[i] = 0xA0000000 + i, memSize_p=8, resetPc_p=0x10.
1. Release reset, ready_i=1 -> valid_o rises after the 2nd edge with instr_o=0xA0000010, instr_addr_o=0x10; then 0x11, 0x12, ... every cycle with no gaps.
2. ready_i=0 for 5 cycles mid-stream while head is 0x14 -> head holds 0x14 and count_q stays ≤2. On ready_i=1, 0x14 then 0x15 then 0x16 arrive with no duplicates or skips.
3. redirect_i for 1 cycle with redirect_addr_i=0x80 while an entry is in flight -> valid_o=0 for 2 cycles, then 0x80, 0x81, ... Pre-redirect words never appear after the redirect.
4. redirect to 0xFE with ready_i=1 -> sequence 0xFE, 0xFF, 0x00, 0x01 (wrap) with data 0xA00000FE, 0xA00000FF, 0xA0000000, 0xA0000001.
5. Assert reset_i for 1 cycle mid-stream, coincident with redirect_i to 0x40 -> all outputs return to reset values and fetch restarts at 0x10, not 0x40.
6. Random ready_i (50%) over 1000 cycles with occasional redirects -> the scoreboard sees strictly sequential addresses between redirects, instr_o = 0xA0000000 + instr_addr_o, and the overflow assertion never fires.

Source files
------------

// File: rtl/corisc_fetch_pkg.sv
// Shared constants and helpers for the instruction fetch front-end.
package corisc_fetch_pkg;

    // Cycles between presenting a ROM address and seeing its data.
    localparam int FETCH_ROM_LATENCY = 1;

    // Number of fetched words the skid buffer can hold.
    localparam int FETCH_BUF_DEPTH = 2;

    // Width of the buffer occupancy counter (holds 0..FETCH_BUF_DEPTH).
    localparam int FETCH_CNT_W = $clog2(FETCH_BUF_DEPTH + 1);

    // True when a new ROM read may be issued without the buffer ever
    // overflowing: words already buffered plus the read in flight, minus
    // the word leaving this cycle, must leave room for one more.
    function automatic logic fetch_has_credit(
        input logic [FETCH_CNT_W-1:0] count,
        input logic                   inflight,
        input logic                   pop
    );
        logic [FETCH_CNT_W:0] occupancy;
        occupancy = {1'b0, count}
                  + {{FETCH_CNT_W{1'b0}}, inflight}
                  - {{FETCH_CNT_W{1'b0}}, pop};
        return occupancy < (FETCH_CNT_W + 1)'(FETCH_BUF_DEPTH);
    endfunction

endpackage

// File: rtl/fetch_skid_fifo.sv
// Two-entry skid buffer holding fetched {instr, addr} pairs in issue order.
// The head entry is always held in head_q so the consumer sees a registered,
// stable word while it stalls.
module fetch_skid_fifo
    import corisc_fetch_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   flush,
    input  logic                   push,
    input  logic [DATA_W-1:0]      push_instr,
    input  logic [ADDR_W-1:0]      push_addr,
    input  logic                   pop,
    output logic [FETCH_CNT_W-1:0] count,
    output logic [DATA_W-1:0]      head_instr,
    output logic [ADDR_W-1:0]      head_addr,
    output logic                   head_valid
);

    typedef struct packed {
        logic [DATA_W-1:0] instr;
        logic [ADDR_W-1:0] addr;
    } entry_t;

    localparam logic [FETCH_CNT_W-1:0] CountFull = FETCH_CNT_W'(FETCH_BUF_DEPTH);
    localparam logic [FETCH_CNT_W-1:0] CountOne  = FETCH_CNT_W'(1);

    entry_t                   head_q;
    entry_t                   tail_q;
    entry_t                   new_entry;
    logic [FETCH_CNT_W-1:0]   count_q;
    logic                     pop_ok;
    logic                     push_ok;

    // Qualify the raw requests so a stray pop on an empty buffer or a push
    // into a full one can never corrupt the stored entries.
    always_comb begin
        new_entry       = '0;
        new_entry.instr = push_instr;
        new_entry.addr  = push_addr;
        pop_ok          = pop && (count_q != '0);
        push_ok         = push && ((count_q != CountFull) || pop_ok);
    end

    // Storage and occupancy update; a flush empties the buffer but leaves
    // stale words in place since they are masked by head_valid.
    always_ff @(posedge clk) begin
        if (reset) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else if (flush) begin
            count_q <= '0;
        end else begin
            case ({push_ok, pop_ok})
                2'b10: begin
                    if (count_q == '0) begin
                        head_q <= new_entry;
                    end else begin
                        tail_q <= new_entry;
                    end
                    count_q <= count_q + CountOne;
                end
                2'b01: begin
                    head_q  <= tail_q;
                    count_q <= count_q - CountOne;
                end
                2'b11: begin
                    if (count_q == CountOne) begin
                        head_q <= new_entry;
                    end else begin
                        head_q <= tail_q;
                        tail_q <= new_entry;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // The issue credit check upstream must keep a push from ever landing on
    // a full buffer that is not draining this cycle.
    overflow_check : assert property (@(posedge clk)
        !(!reset && !flush && push && !pop && (count_q == CountFull)));

    assign count      = count_q;
    assign head_instr = head_q.instr;
    assign head_addr  = head_q.addr;
    assign head_valid = (count_q != '0);

endmodule

// File: rtl/rom_fetch_unit.sv
// Instruction fetch front-end: drives the synchronous ROM address, tracks the
// single outstanding read and hands fetched words to decode through a small
// skid buffer so back-pressure never drops a read.
module rom_fetch_unit
    import corisc_fetch_pkg::*;
#(
    parameter int                    memSize_p   = 8,
    parameter int                    dataWidth_p = 32,
    parameter logic [memSize_p-1:0]  resetPc_p   = '0
) (
    input  logic                   clk_i,
    input  logic                   reset_i,
    output logic [memSize_p-1:0]   rom_addr_o,
    input  logic [dataWidth_p-1:0] rom_data_i,
    input  logic                   redirect_i,
    input  logic [memSize_p-1:0]   redirect_addr_i,
    output logic [dataWidth_p-1:0] instr_o,
    output logic [memSize_p-1:0]   instr_addr_o,
    output logic                   valid_o,
    input  logic                   ready_i
);

    logic [memSize_p-1:0]   pc_q;
    logic [memSize_p-1:0]   tag_q;
    logic                   inflight_q;
    logic [FETCH_CNT_W-1:0] count;
    logic                   pop;
    logic                   issue;

    // A read is launched only when the buffer is guaranteed room for its
    // data; reset and redirect suppress issue because pc_q is being replaced.
    always_comb begin
        pop   = valid_o && ready_i;
        issue = !reset_i && !redirect_i && fetch_has_credit(count, inflight_q, pop);
    end

    // Program counter and outstanding-read tracking; pc_q wraps naturally at
    // the top of the ROM because of its width.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            pc_q       <= resetPc_p;
            tag_q      <= '0;
            inflight_q <= 1'b0;
        end else if (redirect_i) begin
            pc_q       <= redirect_addr_i;
            inflight_q <= 1'b0;
        end else if (issue) begin
            tag_q      <= pc_q;
            inflight_q <= 1'b1;
            pc_q       <= pc_q + memSize_p'(1);
        end else begin
            inflight_q <= 1'b0;
        end
    end

    // Every issued read must be marked in flight when its data returns.
    latency_check : assert property (@(posedge clk_i) disable iff (reset_i)
        issue |-> ##FETCH_ROM_LATENCY inflight_q);

    fetch_skid_fifo #(
        .DATA_W (dataWidth_p),
        .ADDR_W (memSize_p)
    ) u_skid (
        .clk        (clk_i),
        .reset      (reset_i),
        .flush      (redirect_i),
        .push       (inflight_q),
        .push_instr (rom_data_i),
        .push_addr  (tag_q),
        .pop        (pop),
        .count      (count),
        .head_instr (instr_o),
        .head_addr  (instr_addr_o),
        .head_valid (valid_o)
    );

    assign rom_addr_o = pc_q;

endmodule
